// File: rtl/demux_stream_n.sv
// -----------------------------------------------------------------------------
// demux_stream_n
//   Registered 1-to-NCH demultiplexer with valid/ready flow control.
//   Each accepted input beat is steered by in_sel into a one-entry holding
//   register on the chosen output channel (1-clock latency). Channels that
//   are not addressed are never touched. Beats whose select is out of range
//   (only possible when NCH is not a power of two) are consumed, discarded
//   and counted in a saturating drop counter.
//
// Configuration macro:
//   DEMUX_ZERO_IDLE_EN  defined   -> out_data of a channel reads 0 while its
//                                    out_valid is 0 (masking after the register)
//                       undefined -> out_data keeps its last loaded value
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous assert, active-high reset
//   in_data    in   WIDTH      input beat
//   in_sel     in   SELW       destination channel index
//   in_valid   in   1          input beat present
//   in_ready   out  1          beat accepted when in_valid && in_ready
//   out_data   out  NCH*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
//   out_valid  out  NCH        per-channel holding register full
//   out_ready  in   NCH        per-channel consumer accept
//   drop_cnt   out  CNTW       saturating count of out-of-range beats
// -----------------------------------------------------------------------------
module demux_stream_n #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = $clog2(NCH),
    parameter int CNTW  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SELW-1:0]      in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [CNTW-1:0]      drop_cnt
);

    logic [NCH-1:0]   r_valid;
    logic [WIDTH-1:0] r_data [NCH];
    logic [CNTW-1:0]  r_drop_cnt;

    logic [NCH-1:0]   w_hit;      // one-hot decode of in_sel
    logic [NCH-1:0]   w_room;     // channel can take a beat this cycle
    logic [NCH-1:0]   w_acc;      // beat accepted into channel
    logic             w_sel_ok;   // in_sel addresses an existing channel
    logic             w_drop;     // out-of-range beat consumed this cycle

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign w_hit[gi]  = (in_sel == SELW'(gi));
            // A full register can still take a beat when it is draining now.
            assign w_room[gi] = !r_valid[gi] || out_ready[gi];
            assign w_acc[gi]  = in_valid && w_hit[gi] && w_room[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid[gi] <= 1'b0;
                    r_data[gi]  <= '0;
                end else if (w_acc[gi]) begin
                    // Accept wins over a simultaneous fire: valid stays set.
                    r_valid[gi] <= 1'b1;
                    r_data[gi]  <= in_data;
                end else if (out_ready[gi]) begin
                    r_valid[gi] <= 1'b0;
                end
            end

`ifdef DEMUX_ZERO_IDLE_EN
            assign out_data[gi*WIDTH +: WIDTH] = r_valid[gi] ? r_data[gi] : '0;
`else
            assign out_data[gi*WIDTH +: WIDTH] = r_data[gi];
`endif
        end
    endgenerate

    // Only the addressed channel's state feeds in_ready; out-of-range beats
    // are always taken so the producer never stalls on them.
    assign w_sel_ok = |w_hit;
    assign in_ready = w_sel_ok ? |(w_hit & w_room) : 1'b1;
    assign w_drop   = in_valid && !w_sel_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != {CNTW{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + CNTW'(1);
        end
    end

    assign out_valid = r_valid;
    assign drop_cnt  = r_drop_cnt;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && in_valid) begin
            assert (!$isunknown(in_sel));
        end
    end
`endif

endmodule

// File: tb/tb_demux_stream_n.sv
// -----------------------------------------------------------------------------
// tb_demux_stream_n
//   Drives two instances of demux_stream_n: a 4-channel one with an 8-bit
//   drop counter and a 3-channel one with a 2-bit drop counter (so an
//   out-of-range select exists and saturation is reachable quickly).
//   A behavioural model tracks, per channel, whether a beat is held and its
//   value, plus the drop count, and every cycle is compared against it.
// -----------------------------------------------------------------------------
module tb_demux_stream_n;

    logic        clk = 1'b0;
    logic        rst;

    logic [7:0]  in_data4, in_data3;
    logic [1:0]  in_sel4, in_sel3;
    logic        in_valid4, in_valid3;
    logic        in_ready4, in_ready3;
    logic [31:0] out_data4;
    logic [23:0] out_data3;
    logic [3:0]  out_valid4, out_ready4;
    logic [2:0]  out_valid3, out_ready3;
    logic [7:0]  drop_cnt4;
    logic [1:0]  drop_cnt3;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: expected contents of each channel and drop count, per DUT.
    logic        m_valid [2][4];
    logic [7:0]  m_data  [2][4];
    int          m_drop  [2];

    always #5 clk = ~clk;

    demux_stream_n #(.WIDTH(8), .NCH(4), .CNTW(8)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_data(in_data4), .in_sel(in_sel4), .in_valid(in_valid4), .in_ready(in_ready4),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
        .drop_cnt(drop_cnt4)
    );

    demux_stream_n #(.WIDTH(8), .NCH(3), .CNTW(2)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_data(in_data3), .in_sel(in_sel3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .drop_cnt(drop_cnt3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_drop[d] = 0;
            for (int k = 0; k < 4; k++) begin
                m_valid[d][k] = 1'b0;
                m_data[d][k]  = 8'h00;
            end
        end
    endtask

    function automatic int nch_of(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic int sel_of(input int d);
        return (d == 0) ? int'(in_sel4) : int'(in_sel3);
    endfunction

    function automatic logic [3:0] ordy_of(input int d);
        return (d == 0) ? out_ready4 : {1'b0, out_ready3};
    endfunction

    // Producer may hand over a beat when the target slot is empty or being
    // emptied this cycle; nonexistent channels always swallow the beat.
    function automatic logic model_ready(input int d);
        int s;
        logic [3:0] r;
        s = sel_of(d);
        r = ordy_of(d);
        if (s >= nch_of(d)) return 1'b1;
        return !m_valid[d][s] || r[s];
    endfunction

    task automatic model_clock();
        for (int d = 0; d < 2; d++) begin
            int s, n, maxd;
            logic acc;
            logic [3:0] r;
            logic [7:0] dat;
            s    = sel_of(d);
            n    = nch_of(d);
            r    = ordy_of(d);
            maxd = (d == 0) ? 255 : 3;
            dat  = (d == 0) ? in_data4 : in_data3;
            acc  = ((d == 0) ? in_valid4 : in_valid3) && model_ready(d);
            for (int k = 0; k < n; k++) begin
                if (m_valid[d][k] && r[k]) m_valid[d][k] = 1'b0;
            end
            if (acc && s < n) begin
                m_valid[d][s] = 1'b1;
                m_data[d][s]  = dat;
            end
            if (acc && s >= n && m_drop[d] < maxd) m_drop[d]++;
        end
    endtask

    function automatic logic [7:0] exp_data(input int d, input int k);
`ifdef DEMUX_ZERO_IDLE_EN
        return m_valid[d][k] ? m_data[d][k] : 8'h00;
`else
        return m_data[d][k];
`endif
    endfunction

    task automatic check_outputs();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("dut4_valid%0d", k), 64'(out_valid4[k]), 64'(m_valid[0][k]));
            chk($sformatf("dut4_data%0d", k), 64'(out_data4[k*8 +: 8]), 64'(exp_data(0, k)));
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("dut3_valid%0d", k), 64'(out_valid3[k]), 64'(m_valid[1][k]));
            chk($sformatf("dut3_data%0d", k), 64'(out_data3[k*8 +: 8]), 64'(exp_data(1, k)));
        end
        chk("dut4_drop", 64'(drop_cnt4), 64'(m_drop[0]));
        chk("dut3_drop", 64'(drop_cnt3), 64'(m_drop[1]));
    endtask

    // Called with inputs already driven, shortly after a rising edge.
    task automatic cycle();
        #1;
        chk("dut4_in_ready", 64'(in_ready4), 64'(model_ready(0)));
        chk("dut3_in_ready", 64'(in_ready3), 64'(model_ready(1)));
        model_clock();
        @(posedge clk);
        #1;
        check_outputs();
        $display("cycle t=%0t v4=%b s4=%0d d4=%h r4=%b ov4=%b | v3=%b s3=%0d ov3=%b drop3=%0d",
                 $time, in_valid4, in_sel4, in_data4, out_ready4, out_valid4,
                 in_valid3, in_sel3, out_valid3, drop_cnt3);
    endtask

    task automatic idle_inputs();
        in_valid4 = 1'b0; in_sel4 = 2'd0; in_data4 = 8'h00; out_ready4 = 4'h0;
        in_valid3 = 1'b0; in_sel3 = 2'd0; in_data3 = 8'h00; out_ready3 = 3'h0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        #22;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();

        // Out-of-range select on the 3-channel DUT: drop count 1,2,3,3,3.
        for (int i = 0; i < 5; i++) begin
            in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 8'(8'h30 + i);
            cycle();
            chk("illegal_in_ready", 64'(in_ready3), 64'd1);
            chk("illegal_drop", 64'(drop_cnt3), 64'((i < 3) ? i + 1 : 3));
        end
        idle_inputs();

        // Steering: 0xA5 to channel 2 with every consumer ready.
        in_valid4 = 1'b1; in_sel4 = 2'd2; in_data4 = 8'hA5; out_ready4 = 4'hF;
        cycle();
        chk("steer_valid", 64'(out_valid4), 64'h4);
        chk("steer_data", 64'(out_data4[23:16]), 64'hA5);
        idle_inputs();
        cycle();

        // Backpressure on channel 1.
        in_valid4 = 1'b1; in_sel4 = 2'd1; in_data4 = 8'h11; out_ready4 = 4'h0;
        cycle();
        in_data4 = 8'h22;
        cycle();
        chk("bp_in_ready", 64'(in_ready4), 64'd0);
        chk("bp_hold", 64'(out_data4[15:8]), 64'h11);
        out_ready4 = 4'b0010;
        cycle();
        chk("bp_release", 64'(out_data4[15:8]), 64'h22);
        idle_inputs();
        out_ready4 = 4'hF;
        cycle();

        // Streaming 16 back-to-back beats into channel 3.
        for (int i = 0; i < 16; i++) begin
            in_valid4 = 1'b1; in_sel4 = 2'd3; in_data4 = 8'(8'hC0 + i); out_ready4 = 4'b1000;
            cycle();
            chk("stream_ready", 64'(in_ready4), 64'd1);
            chk("stream_data", 64'(out_data4[31:24]), 64'(8'hC0 + i));
        end
        idle_inputs();
        out_ready4 = 4'hF;
        cycle();

        // Idle masking / retention on channel 0.
        in_valid4 = 1'b1; in_sel4 = 2'd0; in_data4 = 8'h5C; out_ready4 = 4'h0;
        cycle();
        idle_inputs();
        out_ready4 = 4'b0001;
        cycle();
`ifdef DEMUX_ZERO_IDLE_EN
        chk("idle_ch0", 64'(out_data4[7:0]), 64'h00);
`else
        chk("idle_ch0", 64'(out_data4[7:0]), 64'h5C);
`endif

        // Randomised traffic on both instances.
        for (int i = 0; i < 300; i++) begin
            in_valid4  = 1'($urandom);
            in_sel4    = 2'($urandom);
            in_data4   = 8'($urandom);
            out_ready4 = 4'($urandom);
            in_valid3  = 1'($urandom);
            in_sel3    = 2'($urandom);
            in_data3   = 8'($urandom);
            out_ready3 = 3'($urandom);
            cycle();
        end

        // Asynchronous reset with channels 0 and 2 full.
        idle_inputs();
        in_valid4 = 1'b1; in_sel4 = 2'd0; in_data4 = 8'h0A;
        cycle();
        in_sel4 = 2'd2; in_data4 = 8'h2A;
        cycle();
        idle_inputs();
        chk("pre_rst_valid", 64'(out_valid4 & 4'b0101), 64'h5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid4", 64'(out_valid4), 64'h0);
        chk("async_rst_data4", 64'(out_data4), 64'h0);
        chk("async_rst_drop4", 64'(drop_cnt4), 64'h0);
        chk("async_rst_drop3", 64'(drop_cnt3), 64'h0);
        chk("async_rst_valid3", 64'(out_valid3), 64'h0);
        model_reset();
        @(posedge clk);
        #4;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
